// File: rtl/proc_pkg.sv
// Shared types and constants for the paper-processor fetch path.
package proc_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    HALT_PEND = 2'd2,
    HALTED    = 2'd3
  } fetch_state_t;

  localparam int unsigned DEF_ADDR_W      = 2;
  localparam int unsigned DEF_DATA_W      = 2;
  localparam int unsigned DEF_CNT_W       = 8;
  localparam logic [1:0]  DEF_HALT_OPCODE = 2'b11;

  // Next sequential PC, wrapping modulo 2**addr_w.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc, input int unsigned addr_w);
    logic [31:0] mask;
    mask = (addr_w >= 32) ? '1 : ((32'd1 << addr_w) - 32'd1);
    return (pc + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts i_inc pulses and sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: owns the PC, reads a combinational instruction
// memory and hands registered words to execute over valid/ready.
module instr_fetch_seq
  import proc_pkg::*;
#(
  parameter int unsigned       ADDR_W      = DEF_ADDR_W,
  parameter int unsigned       DATA_W      = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [DATA_W-1:0] HALT_OPCODE = DATA_W'(DEF_HALT_OPCODE),
  parameter int unsigned       CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              halted,
  output logic              busy,
  output logic [CNT_W-1:0]  fetch_count
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_instr_pc;
  logic [DATA_W-1:0] r_instr_data;
  logic              r_instr_valid;
  logic              w_accept;
  logic              w_load;
  logic              w_is_halt;
  logic [ADDR_W-1:0] w_pc_inc;

  // A load refills the output register whenever it is empty or being drained.
  assign w_accept  = r_instr_valid && instr_ready;
  assign w_load    = (r_state == RUN) && (!r_instr_valid || instr_ready) && !redirect_valid;
  assign w_is_halt = (mem_data == HALT_OPCODE);
  assign w_pc_inc  = ADDR_W'(pc_inc(32'(r_pc), ADDR_W));

  // NOTE: the next-state default comes first so no path through the block can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, HALTED: begin
        if (start) w_state_nxt = RUN;
      end
      RUN: begin
        if (redirect_valid)         w_state_nxt = RUN;
        else if (w_load && w_is_halt) w_state_nxt = HALT_PEND;
      end
      HALT_PEND: begin
        if (redirect_valid) w_state_nxt = RUN;
        else if (w_accept)  w_state_nxt = HALTED;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_instr_data  <= '0;
      r_instr_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Redirect squashes the held word; the data/pc registers keep stale contents.
      if (redirect_valid) begin
        r_pc          <= redirect_addr;
        r_instr_valid <= 1'b0;
      end else if (w_load) begin
        r_instr_data  <= mem_data;
        r_instr_pc    <= r_pc;
        r_instr_valid <= 1'b1;
        r_pc          <= w_pc_inc;
      end else if (w_accept) begin
        r_instr_valid <= 1'b0;
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_fetch_count (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_accept),
    .o_count (fetch_count)
  );

  assign mem_addr    = r_pc;
  assign instr_valid = r_instr_valid;
  assign instr_data  = r_instr_data;
  assign instr_pc    = r_instr_pc;
  assign halted      = (r_state == HALTED);
  assign busy        = (r_state == RUN) || (r_state == HALT_PEND);

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: a default-width instance plus a CNT_W=2
// instance sharing stimulus, each reading its own port of a 4-word program array.
module tb_instr_fetch_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       instr_ready;
  logic       redirect_valid;
  logic [1:0] redirect_addr;
  logic [1:0] mem [4];

  logic [1:0] mem_addr,  mem_data,  instr_data,  instr_pc;
  logic       instr_valid,  halted,  busy;
  logic [7:0] fetch_count;

  logic [1:0] mem_addr2, mem_data2, instr_data2, instr_pc2;
  logic       instr_valid2, halted2, busy2;
  logic [1:0] fetch_count2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign mem_data  = mem[mem_addr];
  assign mem_data2 = mem[mem_addr2];

  instr_fetch_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .halted(halted), .busy(busy), .fetch_count(fetch_count)
  );

  instr_fetch_seq #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start),
    .mem_addr(mem_addr2), .mem_data(mem_data2),
    .instr_valid(instr_valid2), .instr_ready(instr_ready),
    .instr_data(instr_data2), .instr_pc(instr_pc2),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .halted(halted2), .busy(busy2), .fetch_count(fetch_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string tag, input logic ev, input logic [1:0] epc, input logic [1:0] edata);
    check({tag, ".valid"}, 32'(instr_valid), 32'(ev));
    check({tag, ".pc"},    32'(instr_pc),    32'(epc));
    check({tag, ".data"},  32'(instr_data),  32'(edata));
  endtask

  task automatic chk_stat(input string tag, input logic eh, input logic eb,
                          input logic [1:0] eaddr, input logic [7:0] ecnt);
    check({tag, ".halted"}, 32'(halted),      32'(eh));
    check({tag, ".busy"},   32'(busy),        32'(eb));
    check({tag, ".addr"},   32'(mem_addr),    32'(eaddr));
    check({tag, ".count"},  32'(fetch_count), 32'(ecnt));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; instr_ready = 1'b1;
    redirect_valid = 1'b0; redirect_addr = 2'd0;
    mem[0] = 2'b01; mem[1] = 2'b10; mem[2] = 2'b00; mem[3] = 2'b11;

    // Reset values
    do_reset();
    chk_word("rst", 1'b0, 2'd0, 2'd0);
    chk_stat("rst", 1'b0, 1'b0, 2'd0, 8'd0);

    // Program {01,10,00,11}, ready high, run to halt
    start = 1'b1; tick(); start = 1'b0;
    chk_word("t1.c0", 1'b0, 2'd0, 2'd0);
    chk_stat("t1.c0", 1'b0, 1'b1, 2'd0, 8'd0);
    tick(); chk_word("t1.w0", 1'b1, 2'd0, 2'b01);
    tick(); chk_word("t1.w1", 1'b1, 2'd1, 2'b10);
    tick(); chk_word("t1.w2", 1'b1, 2'd2, 2'b00);
    tick(); chk_word("t1.w3", 1'b1, 2'd3, 2'b11);
    chk_stat("t1.pend", 1'b0, 1'b1, 2'd0, 8'd3);
    tick(); chk_word("t1.end", 1'b0, 2'd3, 2'b11);
    chk_stat("t1.end", 1'b1, 1'b0, 2'd0, 8'd4);

    // Stall: ready low for three cycles while (1,10) is held
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    tick(); chk_word("t2.w0", 1'b1, 2'd0, 2'b01);
    tick(); chk_word("t2.w1", 1'b1, 2'd1, 2'b10);
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_word("t2.stall", 1'b1, 2'd1, 2'b10);
      chk_stat("t2.stall", 1'b0, 1'b1, 2'd2, 8'd1);
    end
    instr_ready = 1'b1;
    tick(); chk_word("t2.w2", 1'b1, 2'd2, 2'b00);
    tick(); chk_word("t2.w3", 1'b1, 2'd3, 2'b11);
    tick(); chk_stat("t2.end", 1'b1, 1'b0, 2'd0, 8'd4);

    // Redirect to 3 while (1,10) is valid and not accepted
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    tick(); chk_word("t3.w0", 1'b1, 2'd0, 2'b01);
    tick(); chk_word("t3.w1", 1'b1, 2'd1, 2'b10);
    instr_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 2'd3;
    tick();
    redirect_valid = 1'b0; instr_ready = 1'b1;
    chk_word("t3.squash", 1'b0, 2'd1, 2'b10);
    chk_stat("t3.squash", 1'b0, 1'b1, 2'd3, 8'd1);
    tick(); chk_word("t3.w3", 1'b1, 2'd3, 2'b11);
    chk_stat("t3.pend", 1'b0, 1'b1, 2'd0, 8'd1);
    tick(); chk_stat("t3.end", 1'b1, 1'b0, 2'd0, 8'd2);

    // Program of all 00: six words with PC wrap, never halting
    mem[0] = 2'b00; mem[1] = 2'b00; mem[2] = 2'b00; mem[3] = 2'b00;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    tick(); chk_word("t4.w0", 1'b1, 2'd0, 2'b00);
    tick(); chk_word("t4.w1", 1'b1, 2'd1, 2'b00);
    tick(); chk_word("t4.w2", 1'b1, 2'd2, 2'b00);
    tick(); chk_word("t4.w3", 1'b1, 2'd3, 2'b00);
    chk_stat("t4.w3", 1'b0, 1'b1, 2'd0, 8'd3);
    tick(); chk_word("t4.w4", 1'b1, 2'd0, 2'b00);
    tick(); chk_word("t4.w5", 1'b1, 2'd1, 2'b00);
    chk_stat("t4.w5", 1'b0, 1'b1, 2'd2, 8'd5);

    // Reset mid-RUN with a valid word held, then restart at pc 0
    reset = 1'b1; tick(); reset = 1'b0;
    chk_word("t5.rst", 1'b0, 2'd0, 2'd0);
    chk_stat("t5.rst", 1'b0, 1'b0, 2'd0, 8'd0);
    start = 1'b1; tick(); start = 1'b0;
    tick(); chk_word("t5.w0", 1'b1, 2'd0, 2'b00);

    // Halt mid-program, resume at next pc, and saturate the CNT_W=2 counter
    mem[0] = 2'b00; mem[1] = 2'b11; mem[2] = 2'b00; mem[3] = 2'b00;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    tick(); chk_word("t6.w0", 1'b1, 2'd0, 2'b00);
    tick(); chk_word("t6.w1", 1'b1, 2'd1, 2'b11);
    tick(); chk_stat("t6.halt", 1'b1, 1'b0, 2'd2, 8'd2);
    chk_word("t6.halt", 1'b0, 2'd1, 2'b11);
    start = 1'b1; tick(); start = 1'b0;
    chk_stat("t6.resume", 1'b0, 1'b1, 2'd2, 8'd2);
    tick(); chk_word("t6.w2", 1'b1, 2'd2, 2'b00);
    tick(); check("t6.cnt2_a", 32'(fetch_count2), 32'd3);
    tick(); check("t6.cnt2_b", 32'(fetch_count2), 32'd3);
    tick(); chk_word("t6.w5", 1'b1, 2'd1, 2'b11);
    chk_stat("t6.w5", 1'b0, 1'b1, 2'd2, 8'd5);
    check("t6.cnt2_sat", 32'(fetch_count2), 32'd3);

    // Simultaneous start and redirect in IDLE
    do_reset();
    start = 1'b1; redirect_valid = 1'b1; redirect_addr = 2'd2;
    tick();
    start = 1'b0; redirect_valid = 1'b0;
    chk_word("t7.c0", 1'b0, 2'd0, 2'd0);
    chk_stat("t7.c0", 1'b0, 1'b1, 2'd2, 8'd0);
    tick(); chk_word("t7.w", 1'b1, 2'd2, 2'b00);
    check("t7.d2.valid",  32'(instr_valid2),  32'd1);
    check("t7.d2.pc",     32'(instr_pc2),     32'd2);
    check("t7.d2.data",   32'(instr_data2),   32'd0);
    check("t7.d2.halted", 32'(halted2),       32'd0);
    check("t7.d2.busy",   32'(busy2),         32'd1);
    check("t7.d2.addr",   32'(mem_addr2),     32'd3);
    check("t7.d2.count",  32'(fetch_count2),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
